sap1_control_sequencer: RTL

Microcoded control sequencer for the SAP-1 datapath. It steps a fetch/execute T-state counter, decodes the IR opcode, and drives the bus-drive selects and load enables of the PC, MAR, IR, A, B, OUT and flags registers and the RAM. It advances only on `mclk` edges with `mclk_en` high, in lockstep with the registers it controls. Those registers gate their own loads with `mclk_en`, so every control output here is a level signal valid for the whole step.

---
 rtl/sap1_pkg.sv | 41 ++++
 rtl/sap1_microcode_rom.sv | 121 ++++++++++++
 rtl/sap1_control_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, T-states,
// control-word bit positions and the packed control-word type.
package sap1_pkg;

  // Opcode values carried in IR[7:4]
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-state encodings (T1 is the first fetch step)
  localparam logic [2:0] T1 = 3'd0;
  localparam logic [2:0] T2 = 3'd1;
  localparam logic [2:0] T3 = 3'd2;
  localparam logic [2:0] T4 = 3'd3;
  localparam logic [2:0] T5 = 3'd4;

  // Control-word bit positions
  localparam int CW_PC_OUT     = 0;
  localparam int CW_RAM_OUT    = 1;
  localparam int CW_IR_OUT     = 2;
  localparam int CW_A_OUT      = 3;
  localparam int CW_ALU_OUT    = 4;
  localparam int CW_MAR_LOAD   = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_A_LOAD     = 7;
  localparam int CW_B_LOAD     = 8;
  localparam int CW_OUT_LOAD   = 9;
  localparam int CW_FLAGS_LOAD = 10;
  localparam int CW_PC_LOAD    = 11;
  localparam int CW_PC_INC     = 12;
  localparam int CW_ALU_SUB    = 13;
  localparam int CW_WIDTH      = 14;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

endpackage : sap1_pkg

// File: rtl/sap1_microcode_rom.sv
// Combinational microcode: maps {opcode, step, carry, zero} to the control
// word for that step, plus whether it is the instruction's last step and
// whether leaving it enters the halted state.
module sap1_microcode_rom
  import sap1_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [STEP_WIDTH-1:0]   i_step,
  input  logic                    i_flag_carry,
  input  logic                    i_flag_zero,
  output ctrl_word_t              o_ctrl,
  output logic                    o_last_step,
  output logic                    o_halt
);

  // Decode the current step of the current instruction into control bits
  always_comb begin
    o_ctrl      = '0;
    o_last_step = 1'b0;
    o_halt      = 1'b0;
    case (i_step)
      STEP_WIDTH'(T1): begin
        o_ctrl[CW_PC_OUT]   = 1'b1;
        o_ctrl[CW_MAR_LOAD] = 1'b1;
      end
      STEP_WIDTH'(T2): begin
        o_ctrl[CW_RAM_OUT] = 1'b1;
        o_ctrl[CW_IR_LOAD] = 1'b1;
        o_ctrl[CW_PC_INC]  = 1'b1;
      end
      STEP_WIDTH'(T3): begin
        case (i_opcode)
          OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
            o_ctrl[CW_IR_OUT]   = 1'b1;
            o_ctrl[CW_MAR_LOAD] = 1'b1;
          end
          OPCODE_WIDTH'(OP_JMP): begin
            o_ctrl[CW_IR_OUT]  = 1'b1;
            o_ctrl[CW_PC_LOAD] = 1'b1;
            o_last_step        = 1'b1;
          end
          OPCODE_WIDTH'(OP_JC): begin
            if (i_flag_carry) begin
              o_ctrl[CW_IR_OUT]  = 1'b1;
              o_ctrl[CW_PC_LOAD] = 1'b1;
            end else begin
              o_ctrl = '0;
            end
            o_last_step = 1'b1;
          end
          OPCODE_WIDTH'(OP_JZ): begin
            if (i_flag_zero) begin
              o_ctrl[CW_IR_OUT]  = 1'b1;
              o_ctrl[CW_PC_LOAD] = 1'b1;
            end else begin
              o_ctrl = '0;
            end
            o_last_step = 1'b1;
          end
          OPCODE_WIDTH'(OP_OUT): begin
            o_ctrl[CW_A_OUT]    = 1'b1;
            o_ctrl[CW_OUT_LOAD] = 1'b1;
            o_last_step         = 1'b1;
          end
          OPCODE_WIDTH'(OP_HLT): begin
            o_last_step = 1'b1;
            o_halt      = 1'b1;
          end
          default: begin
            o_last_step = 1'b1;
          end
        endcase
      end
      STEP_WIDTH'(T4): begin
        case (i_opcode)
          OPCODE_WIDTH'(OP_LDA): begin
            o_ctrl[CW_RAM_OUT] = 1'b1;
            o_ctrl[CW_A_LOAD]  = 1'b1;
            o_last_step        = 1'b1;
          end
          OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
            o_ctrl[CW_RAM_OUT] = 1'b1;
            o_ctrl[CW_B_LOAD]  = 1'b1;
          end
          default: begin
            // Short instructions never reach T4; recover to fetch.
            o_last_step = 1'b1;
          end
        endcase
      end
      STEP_WIDTH'(T5): begin
        case (i_opcode)
          OPCODE_WIDTH'(OP_ADD): begin
            o_ctrl[CW_ALU_OUT]    = 1'b1;
            o_ctrl[CW_A_LOAD]     = 1'b1;
            o_ctrl[CW_FLAGS_LOAD] = 1'b1;
          end
          OPCODE_WIDTH'(OP_SUB): begin
            o_ctrl[CW_ALU_OUT]    = 1'b1;
            o_ctrl[CW_A_LOAD]     = 1'b1;
            o_ctrl[CW_FLAGS_LOAD] = 1'b1;
            o_ctrl[CW_ALU_SUB]    = 1'b1;
          end
          default: begin
            o_ctrl = '0;
          end
        endcase
        // T5 is always the end, so the counter can never pass it.
        o_last_step = 1'b1;
      end
      default: begin
        // Unreachable step codes fall back to fetch with no controls.
        o_last_step = 1'b1;
      end
    endcase
  end

endmodule : sap1_microcode_rom

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer top: T-state counter, halted bit, reset masking
// of the microcode outputs and unpacking into individual control lines.
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    mclk,
  input  logic                    mrst_n,
  input  logic                    mclk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_flag_carry,
  input  logic                    i_flag_zero,
  output logic                    o_pc_out,
  output logic                    o_ram_out,
  output logic                    o_ir_out,
  output logic                    o_a_out,
  output logic                    o_alu_out,
  output logic                    o_mar_load,
  output logic                    o_ir_load,
  output logic                    o_a_load,
  output logic                    o_b_load,
  output logic                    o_out_load,
  output logic                    o_flags_load,
  output logic                    o_pc_load,
  output logic                    o_pc_inc,
  output logic                    o_alu_sub,
  output logic                    o_halted,
  output logic [STEP_WIDTH-1:0]   o_step
);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  ctrl_word_t            rom_ctrl_s;
  logic                  rom_last_s;
  logic                  rom_halt_s;
  ctrl_word_t            ctrl_s;

  sap1_microcode_rom #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .STEP_WIDTH   (STEP_WIDTH)
  ) u_rom (
    .i_opcode     (i_opcode),
    .i_step       (step_q),
    .i_flag_carry (i_flag_carry),
    .i_flag_zero  (i_flag_zero),
    .o_ctrl       (rom_ctrl_s),
    .o_last_step  (rom_last_s),
    .o_halt       (rom_halt_s)
  );

  // Next step/halted: halted parks at T1, otherwise advance or wrap on enabled edges
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d   = STEP_WIDTH'(T1);
      halted_d = 1'b1;
    end else if (mclk_en) begin
      if (rom_last_s) begin
        step_d   = STEP_WIDTH'(T1);
        halted_d = rom_halt_s;
      end else begin
        step_d   = step_q + STEP_WIDTH'(1);
        halted_d = 1'b0;
      end
    end else begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  // State register with synchronous active-low reset that overrides the enable
  always_ff @(posedge mclk) begin
    if (!mrst_n) begin
      step_q   <= STEP_WIDTH'(T1);
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Controls are silenced while in reset and while halted
  always_comb begin
    ctrl_s = '0;
    if (mrst_n && !halted_q) begin
      ctrl_s = rom_ctrl_s;
    end else begin
      ctrl_s = '0;
    end
  end

  assign o_pc_out     = ctrl_s[CW_PC_OUT];
  assign o_ram_out    = ctrl_s[CW_RAM_OUT];
  assign o_ir_out     = ctrl_s[CW_IR_OUT];
  assign o_a_out      = ctrl_s[CW_A_OUT];
  assign o_alu_out    = ctrl_s[CW_ALU_OUT];
  assign o_mar_load   = ctrl_s[CW_MAR_LOAD];
  assign o_ir_load    = ctrl_s[CW_IR_LOAD];
  assign o_a_load     = ctrl_s[CW_A_LOAD];
  assign o_b_load     = ctrl_s[CW_B_LOAD];
  assign o_out_load   = ctrl_s[CW_OUT_LOAD];
  assign o_flags_load = ctrl_s[CW_FLAGS_LOAD];
  assign o_pc_load    = ctrl_s[CW_PC_LOAD];
  assign o_pc_inc     = ctrl_s[CW_PC_INC];
  assign o_alu_sub    = ctrl_s[CW_ALU_SUB];
  assign o_halted     = mrst_n & halted_q;
  assign o_step       = mrst_n ? step_q : '0;

endmodule : sap1_control_sequencer
